// File: rtl/decode_ib_sequencer_pkg.sv
// decode_ib_sequencer_pkg: shared types and configuration constants
// for the decode to instruction-buffer sequencer.
package decode_ib_sequencer_pkg;

    localparam int FETCH_WIDTH   = 4;
    localparam int SLOTS_DEF     = 2 * FETCH_WIDTH;
    localparam int OUT_WIDTH_DEF = 4;

    typedef struct packed {
        logic [7:0]  tag;
        logic [23:0] data;
    } renPkt;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } seqState_t;

endpackage

// File: rtl/decode_ib_sequencer_if.sv
// decode_ib_sequencer_if: bundle-in / ibuf-out signal group.
// slave = sequencer side, master = decode/ibuf side.
// Optional laneActive_i exists only with DECODE_SEQ_LANE_GATE_EN.
interface decode_ib_sequencer_if
    import decode_ib_sequencer_pkg::*;
#(
    parameter int SLOTS     = SLOTS_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF
);
    localparam int CW = $clog2(OUT_WIDTH + 1);

    logic                 bundleValid_i;
    logic [SLOTS-1:0]     slotValid_i;
    renPkt                slot_i [SLOTS];
    logic [CW-1:0]        ibFree_i;
    logic                 flush_i;
`ifdef DECODE_SEQ_LANE_GATE_EN
    logic [SLOTS/2-1:0]   laneActive_i;
`endif
    logic                 bundleReady_o;
    logic [OUT_WIDTH-1:0] outValid_o;
    renPkt                outPkt_o [OUT_WIDTH];
    logic [CW-1:0]        outCnt_o;
    logic                 busy_o;

    modport slave (
`ifdef DECODE_SEQ_LANE_GATE_EN
        input  laneActive_i,
`endif
        input  bundleValid_i, slotValid_i, slot_i,
        input  ibFree_i, flush_i,
        output bundleReady_o, outValid_o, outPkt_o,
        output outCnt_o, busy_o
    );

    modport master (
`ifdef DECODE_SEQ_LANE_GATE_EN
        output laneActive_i,
`endif
        output bundleValid_i, slotValid_i, slot_i,
        output ibFree_i, flush_i,
        input  bundleReady_o, outValid_o, outPkt_o,
        input  outCnt_o, busy_o
    );

endinterface

// File: rtl/decode_seq_compactor.sv
// decode_seq_compactor: picks the first limit_i set bits of mask_i and
// packs those slots, in ascending order, onto lanes 0.. (combinational).
// Ports: mask_i/pkt_i slots in, limit_i cap; valid_o/pkt_o/cnt_o lanes
// out, take_o = slots consumed, pop_o = popcount(mask_i).
module decode_seq_compactor
    import decode_ib_sequencer_pkg::*;
#(
    parameter int SLOTS     = SLOTS_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF,
    parameter int CW        = $clog2(OUT_WIDTH + 1),
    parameter int PW        = $clog2(SLOTS + 1)
) (
    input  logic [SLOTS-1:0]     mask_i,
    input  renPkt                pkt_i [SLOTS],
    input  logic [CW-1:0]        limit_i,
    output logic [OUT_WIDTH-1:0] valid_o,
    output renPkt                pkt_o [OUT_WIDTH],
    output logic [CW-1:0]        cnt_o,
    output logic [SLOTS-1:0]     take_o,
    output logic [PW-1:0]        pop_o
);

    always_comb begin
        valid_o = '0;
        take_o  = '0;
        cnt_o   = '0;
        pop_o   = '0;
        for (int l = 0; l < OUT_WIDTH; l++) begin
            pkt_o[l] = '0;
        end
        for (int i = 0; i < SLOTS; i++) begin
            if (mask_i[i]) begin
                pop_o = pop_o + PW'(1);
                if (cnt_o < limit_i) begin
                    for (int l = 0; l < OUT_WIDTH; l++) begin
                        if (CW'(l) == cnt_o) begin
                            pkt_o[l]   = pkt_i[i];
                            valid_o[l] = 1'b1;
                        end
                    end
                    take_o[i] = 1'b1;
                    cnt_o     = cnt_o + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/decode_ib_sequencer.sv
// decode_ib_sequencer: buffers one decoded bundle and drains it into the
// instruction buffer, up to min(OUT_WIDTH, ibFree_i) micro-ops per cycle.
// Ports: clk, reset (async, active low), io (decode_ib_sequencer_if.slave).
// DECODE_SEQ_LANE_GATE_EN adds laneActive_i gating of slot pairs at capture.
module decode_ib_sequencer
    import decode_ib_sequencer_pkg::*;
#(
    parameter int SLOTS     = SLOTS_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    decode_ib_sequencer_if.slave io
);

    localparam int CW = $clog2(OUT_WIDTH + 1);
    localparam int PW = $clog2(SLOTS + 1);

    seqState_t            state_q, state_d;
    logic [SLOTS-1:0]     pend_q, pend_d;
    renPkt                hold_q [SLOTS];
    renPkt                hold_d [SLOTS];
    logic [SLOTS-1:0]     gate, cap_mask, sel_mask, take;
    logic [CW-1:0]        limit, grant;
    logic [PW-1:0]        pop;
    logic [OUT_WIDTH-1:0] cmp_valid;
    renPkt                cmp_pkt [OUT_WIDTH];
    logic                 drain_all, ready, accept, load;

`ifdef DECODE_SEQ_LANE_GATE_EN
    always_comb begin
        gate = '1;
        for (int g = 0; g < SLOTS / 2; g++) begin
            gate[2*g]   = io.laneActive_i[g];
            gate[2*g+1] = io.laneActive_i[g];
        end
    end
`else
    assign gate = '1;
`endif

    assign cap_mask = io.slotValid_i & gate;
    assign limit    = (io.ibFree_i > CW'(OUT_WIDTH)) ? CW'(OUT_WIDTH)
                                                     : io.ibFree_i;
    assign sel_mask = (state_q == DRAIN) ? pend_q : '0;

    decode_seq_compactor #(
        .SLOTS     (SLOTS),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_compactor (
        .mask_i  (sel_mask),
        .pkt_i   (hold_q),
        .limit_i (limit),
        .valid_o (cmp_valid),
        .pkt_o   (cmp_pkt),
        .cnt_o   (grant),
        .take_o  (take),
        .pop_o   (pop)
    );

    // This beat empties the holding register, so a new bundle can land.
    assign drain_all = (state_q == DRAIN) && (PW'(grant) == pop);
    assign ready     = !io.flush_i && ((state_q == IDLE) || drain_all);
    assign accept    = io.bundleValid_i && ready;

    assign io.bundleReady_o = ready;
    assign io.outValid_o    = io.flush_i ? '0 : cmp_valid;
    assign io.outCnt_o      = io.flush_i ? '0 : grant;
    assign io.outPkt_o      = cmp_pkt;
    assign io.busy_o        = (state_q == DRAIN);

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        load    = 1'b0;
        if (io.flush_i) begin
            state_d = IDLE;
            pend_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept && |cap_mask) begin
                        load    = 1'b1;
                        pend_d  = cap_mask;
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    pend_d = pend_q & ~take;
                    if (accept) begin
                        load    = |cap_mask;
                        pend_d  = cap_mask;
                        state_d = |cap_mask ? DRAIN : IDLE;
                    end else if (pend_d == '0) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    pend_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            hold_d[i] = load ? io.slot_i[i] : hold_q[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    // Payload is qualified by pend_q, so it carries no reset.
    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

endmodule

// File: tb/tb_decode_ib_sequencer.sv
// tb_decode_ib_sequencer: table-driven bench for decode_ib_sequencer
// plus hand sequences for reset mid-drain and lane gating.
module tb_decode_ib_sequencer;
    import decode_ib_sequencer_pkg::*;

    typedef struct {
        logic        bv;
        logic [3:0]  bid;
        logic [7:0]  mask;
        logic [2:0]  ib;
        logic        fl;
        logic        rdy;
        logic [3:0]  vld;
        logic [2:0]  cnt;
        logic        busy;
        logic [31:0] tg;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    vec_t tv [27];

    always #5 clk = ~clk;

    decode_ib_sequencer_if #(.SLOTS(8), .OUT_WIDTH(4)) bus ();

    decode_ib_sequencer #(.SLOTS(8), .OUT_WIDTH(4)) dut (
        .clk   (clk),
        .reset (rst_n),
        .io    (bus.slave)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic bv, input logic [3:0] bid,
                         input logic [7:0] mask, input logic [2:0] ib,
                         input logic fl);
        bus.bundleValid_i = bv;
        bus.slotValid_i   = mask;
        bus.ibFree_i      = ib;
        bus.flush_i       = fl;
        for (int i = 0; i < 8; i++) begin
            bus.slot_i[i].tag  = {bid, 4'(i)};
            bus.slot_i[i].data = 24'(i * 7 + 1);
        end
    endtask

    task automatic chk_tags(input string nm, input logic [3:0] vld,
                            input logic [31:0] tg);
        for (int l = 0; l < 4; l++) begin
            if (vld[l]) begin
                chk($sformatf("%s.tag%0d", nm, l),
                    32'(bus.outPkt_o[l].tag), 32'(tg[8*l +: 8]));
            end
        end
    endtask

    initial begin
        tv[0]  = '{1, 1, 8'hFF, 4, 0, 1, 4'h0, 0, 0, 32'h0};
        tv[1]  = '{0, 0, 8'h00, 4, 0, 0, 4'hF, 4, 1, 32'h13121110};
        tv[2]  = '{0, 0, 8'h00, 4, 0, 1, 4'hF, 4, 1, 32'h17161514};
        tv[3]  = '{0, 0, 8'h00, 4, 0, 1, 4'h0, 0, 0, 32'h0};
        tv[4]  = '{1, 2, 8'hA5, 4, 0, 1, 4'h0, 0, 0, 32'h0};
        tv[5]  = '{0, 0, 8'h00, 4, 0, 1, 4'hF, 4, 1, 32'h27252220};
        tv[6]  = '{0, 0, 8'h00, 4, 0, 1, 4'h0, 0, 0, 32'h0};
        tv[7]  = '{1, 3, 8'hFF, 0, 0, 1, 4'h0, 0, 0, 32'h0};
        tv[8]  = '{0, 0, 8'h00, 0, 0, 0, 4'h0, 0, 1, 32'h0};
        tv[9]  = '{0, 0, 8'h00, 3, 0, 0, 4'h7, 3, 1, 32'h00323130};
        tv[10] = '{0, 0, 8'h00, 0, 0, 0, 4'h0, 0, 1, 32'h0};
        tv[11] = '{0, 0, 8'h00, 5, 0, 0, 4'hF, 4, 1, 32'h36353433};
        tv[12] = '{0, 0, 8'h00, 5, 0, 1, 4'h1, 1, 1, 32'h00000037};
        tv[13] = '{0, 0, 8'h00, 4, 0, 1, 4'h0, 0, 0, 32'h0};
        tv[14] = '{1, 4, 8'h0F, 4, 0, 1, 4'h0, 0, 0, 32'h0};
        tv[15] = '{1, 5, 8'hF0, 4, 0, 1, 4'hF, 4, 1, 32'h43424140};
        tv[16] = '{0, 0, 8'h00, 4, 0, 1, 4'hF, 4, 1, 32'h57565554};
        tv[17] = '{0, 0, 8'h00, 4, 0, 1, 4'h0, 0, 0, 32'h0};
        tv[18] = '{1, 6, 8'hFF, 4, 0, 1, 4'h0, 0, 0, 32'h0};
        tv[19] = '{0, 0, 8'h00, 3, 0, 0, 4'h7, 3, 1, 32'h00626160};
        tv[20] = '{1, 7, 8'hFF, 4, 1, 0, 4'h0, 0, 1, 32'h0};
        tv[21] = '{0, 0, 8'h00, 4, 0, 1, 4'h0, 0, 0, 32'h0};
        tv[22] = '{1, 8, 8'h01, 4, 0, 1, 4'h0, 0, 0, 32'h0};
        tv[23] = '{0, 0, 8'h00, 4, 0, 1, 4'h1, 1, 1, 32'h00000080};
        tv[24] = '{0, 0, 8'h00, 4, 0, 1, 4'h0, 0, 0, 32'h0};
        tv[25] = '{1, 9, 8'h00, 4, 0, 1, 4'h0, 0, 0, 32'h0};
        tv[26] = '{0, 0, 8'h00, 4, 0, 1, 4'h0, 0, 0, 32'h0};

`ifdef DECODE_SEQ_LANE_GATE_EN
        bus.laneActive_i = 4'b1111;
`endif
        drive(0, 0, 8'h00, 4, 0);

        #12;
        chk("rst.vld",  32'(bus.outValid_o), 32'h0);
        chk("rst.cnt",  32'(bus.outCnt_o), 32'h0);
        chk("rst.busy", 32'(bus.busy_o), 32'h0);
        chk("rst.rdy",  32'(bus.bundleReady_o), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            @(posedge clk);
            #1;
            drive(tv[i].bv, tv[i].bid, tv[i].mask, tv[i].ib, tv[i].fl);
            @(negedge clk);
            chk($sformatf("v%0d.rdy", i), 32'(bus.bundleReady_o),
                32'(tv[i].rdy));
            chk($sformatf("v%0d.vld", i), 32'(bus.outValid_o),
                32'(tv[i].vld));
            chk($sformatf("v%0d.cnt", i), 32'(bus.outCnt_o),
                32'(tv[i].cnt));
            chk($sformatf("v%0d.busy", i), 32'(bus.busy_o),
                32'(tv[i].busy));
            chk_tags($sformatf("v%0d", i), tv[i].vld, tv[i].tg);
        end

        // Reset asserted in the middle of a drain.
        @(posedge clk); #1;
        drive(1, 4'hA, 8'hFF, 4, 0);
        @(posedge clk); #1;
        drive(0, 0, 8'h00, 4, 0);
        @(negedge clk);
        chk("mr.beat.vld", 32'(bus.outValid_o), 32'hF);
        chk_tags("mr.beat", 4'hF, 32'hA3A2A1A0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mr.rst.busy", 32'(bus.busy_o), 32'h0);
        chk("mr.rst.vld",  32'(bus.outValid_o), 32'h0);
        chk("mr.rst.cnt",  32'(bus.outCnt_o), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1, 4'hB, 8'h03, 4, 0);
        @(negedge clk);
        chk("mr.acc.rdy", 32'(bus.bundleReady_o), 32'h1);
        chk("mr.acc.vld", 32'(bus.outValid_o), 32'h0);
        @(posedge clk); #1;
        drive(0, 0, 8'h00, 4, 0);
        @(negedge clk);
        chk("mr.new.vld", 32'(bus.outValid_o), 32'h3);
        chk("mr.new.cnt", 32'(bus.outCnt_o), 32'h2);
        chk_tags("mr.new", 4'h3, 32'h0000B1B0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mr.end.vld",  32'(bus.outValid_o), 32'h0);
        chk("mr.end.busy", 32'(bus.busy_o), 32'h0);

`ifdef DECODE_SEQ_LANE_GATE_EN
        @(posedge clk); #1;
        bus.laneActive_i = 4'b1110;
        drive(1, 4'hC, 8'hFF, 4, 0);
        @(posedge clk); #1;
        bus.laneActive_i = 4'b1111;
        drive(0, 0, 8'h00, 4, 0);
        @(negedge clk);
        chk("lg.b1.vld", 32'(bus.outValid_o), 32'hF);
        chk_tags("lg.b1", 4'hF, 32'hC5C4C3C2);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lg.b2.vld", 32'(bus.outValid_o), 32'h3);
        chk("lg.b2.cnt", 32'(bus.outCnt_o), 32'h2);
        chk_tags("lg.b2", 4'h3, 32'h0000C7C6);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lg.end.busy", 32'(bus.busy_o), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_ib_sequencer.md
DECODE_IB_SEQUENCER -- requirements
Module: decode_ib_sequencer

Interface
REQ-001 SHALL have parameter SLOTS, default 8, micro-op slots per decoded bundle (2 x FETCH_WIDTH).
REQ-002 SHALL have parameter OUT_WIDTH, default 4, maximum micro-ops written to the instruction buffer per cycle.
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port bundleValid_i  input  1  decoded bundle present.
REQ-006 SHALL have port slotValid_i  input  SLOTS  per-slot valid mask; bit i qualifies slot i.
REQ-007 SHALL have port slot_i  input  renPkt[SLOTS]  decoded micro-ops, slot 2g/2g+1 from fetch lane g.
REQ-008 SHALL have port ibFree_i  input  $clog2(OUT_WIDTH+1)  instruction-buffer entries free this cycle; values above OUT_WIDTH are treated as OUT_WIDTH.
REQ-009 SHALL have port flush_i  input  1  pipeline flush.
REQ-010 SHALL have port bundleReady_o  output  1  bundle accepted this cycle when high together with bundleValid_i.
REQ-011 SHALL have port outValid_o  output  OUT_WIDTH  per-lane write enable, always contiguous from lane 0.
REQ-012 SHALL have port outPkt_o  output  renPkt[OUT_WIDTH]  micro-ops to the instruction buffer.
REQ-013 SHALL have port outCnt_o  output  $clog2(OUT_WIDTH+1)  popcount of outValid_o.
REQ-014 SHALL have port busy_o  output  1  high while in DRAIN.

Function
REQ-015 SHALL implement states IDLE and DRAIN, backed by a holding register (SLOTS packets) and a pending mask.
REQ-016 SHALL, in IDLE, assert bundleReady_o unless flush_i is high.
REQ-017 SHALL, on acceptance with a nonzero mask, capture slot_i and the mask and enter DRAIN the next cycle.
REQ-018 SHALL, on acceptance with an all-zero mask, remain in IDLE and emit nothing.
REQ-019 SHALL, in DRAIN, compute grant = min(popcount(pending), OUT_WIDTH, ibFree_i).
REQ-020 SHALL emit the grant lowest-indexed pending slots, in ascending slot order, on lanes 0..grant-1.
REQ-021 SHALL clear the emitted pending bits at the clock edge.
REQ-022 SHALL drive outValid_o and outPkt_o combinationally from the holding register; first emission occurs one cycle after acceptance.
REQ-023 SHALL hold the emission, with no progress and no output, when ibFree_i = 0.
REQ-024 SHALL, in DRAIN, assert bundleReady_o only when grant equals popcount(pending) and flush_i is low.
REQ-025 SHALL, on a same-cycle final drain and acceptance, overwrite the holding register; the next state is DRAIN for a nonzero new mask, otherwise IDLE.
REQ-026 SHALL otherwise return to IDLE once the pending mask reaches zero.
REQ-027 SHALL, while flush_i is high, force outValid_o = 0 and bundleReady_o = 0 in the same cycle.
REQ-028 SHALL, on a flush, clear the pending mask and be in IDLE on the next cycle; flush has priority over all other events.
REQ-029 SHALL ignore outPkt_o contents on lanes whose outValid_o bit is 0; those lanes are don't-care.

Reset
REQ-030 SHALL, while reset is low, asynchronously force state IDLE and pending mask 0.
REQ-031 SHALL, while reset is low, drive outValid_o = 0, outCnt_o = 0 and busy_o = 0; bundleReady_o follows REQ-016.
REQ-032 SHALL, on reset asserted mid-drain, discard the remaining slots with no partial emission afterwards.
REQ-033 SHALL leave the holding-register payload unreset.

Configuration
REQ-034 SHALL, with DECODE_SEQ_LANE_GATE_EN defined, add input laneActive_i [SLOTS/2] and AND slotValid_i bits 2g and 2g+1 with laneActive_i[g] at capture.
REQ-035 SHALL, without DECODE_SEQ_LANE_GATE_EN, omit the laneActive_i port and treat every lane as active.

Structure
REQ-036 SHALL declare seqState_t (IDLE, DRAIN) in the shared package; renPkt remains the existing package type.
REQ-037 SHALL take the FETCH_WIDTH-derived SLOTS default from the shared configuration constants.
REQ-038 SHALL place the first-N-set-bits selection and lane compaction in sub-module decode_seq_compactor (purely combinational, parameterised by SLOTS and OUT_WIDTH).

Verification
REQ-039 SHALL cover: mask 8'hFF, ibFree_i = 4 -> two beats of 4 (slots 0-3, then 4-7); bundleReady_o high on beat 2; busy_o low after.
REQ-040 SHALL cover: mask 8'b1010_0101, ibFree_i = 4 -> one beat, lanes 0-3 = slots 0,2,5,7, outCnt_o = 4.
REQ-041 SHALL cover: mask 8'hFF, ibFree_i sequence 0,3,0,5 -> beats of 0,3,0,4 then 1; slot order 0..7 is preserved.
REQ-042 SHALL cover: back-to-back bundles 8'h0F then 8'hF0, ibFree_i = 4 -> second bundle accepted on the first beat, emitted the next cycle with no bubble.
REQ-043 SHALL cover: flush_i pulse during DRAIN with 5 slots pending -> outValid_o = 0 that cycle, IDLE next cycle, no stale slot ever emitted.
REQ-044 SHALL cover: reset low mid-drain, then a new bundle with mask 8'h03 -> only the new slots 0,1 appear; with DECODE_SEQ_LANE_GATE_EN, laneActive_i = 4'b1110 and mask 8'hFF -> only slots 2-7 are emitted.
